// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Definitions shared by ram_loader and the RAM it feeds.
//               - RAM command encodings: LOCK / READ / WRITE
//               - word, byte, address and counter widths
//               - loader FSM state encoding
//               - put_byte(): inserts one byte into a word at a byte index
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int c_BYTE_W         = 8;
    localparam int c_BYTES_PER_WORD = 16;
    localparam int c_WORD_W         = c_BYTE_W * c_BYTES_PER_WORD;
    localparam int c_ADDR_W         = 8;
    localparam int c_CNT_W          = 4;

    // RAM command bus encoding.
    typedef enum logic [1:0] {
        RW_LOCK  = 2'd0,
        RW_READ  = 2'd1,
        RW_WRITE = 2'd2
    } rw_cmd_e;

    // Loader state encoding.
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DONE   = 2'd2
    } ldr_state_e;

    // Places byte b at byte lane idx of word. Lane k occupies
    // bits [8k+7:8k], so RAM byte address k maps to lane k.
    function automatic logic [c_WORD_W-1:0] put_byte(
        input logic [c_WORD_W-1:0] word,
        input logic [c_CNT_W-1:0]  idx,
        input logic [c_BYTE_W-1:0] b
    );
        logic [c_WORD_W-1:0] word_o;
        word_o = word;
        word_o[{idx, 3'b000} +: c_BYTE_W] = b;
        return word_o;
    endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Collects a byte stream into 128-bit words and commits each
//               word to a RAM with a single-cycle Write command. Between
//               commits, consumer reads are forwarded to the RAM.
//
//               Configuration macro: RAM_LOADER_PAD_EN
//                 defined   : a frame ended early by in_last is zero-padded
//                             in its unfilled upper bytes and committed.
//                 undefined : a short frame is discarded and err is set.
//
// Ports       : clk        - rising-edge clock
//               rst_n      - synchronous active-low reset
//               in_valid   - upstream byte valid
//               in_data    - upstream byte [7:0]
//               in_last    - last byte of frame (qualified by in_valid)
//               in_ready   - loader can accept a byte (FILL state only)
//               rd_req     - consumer read request
//               rd_addr    - consumer read address [7:0]
//               rd_gnt     - read forwarded to RAM this cycle
//               rw         - RAM command (LOCK=0, READ=1, WRITE=2)
//               addr       - RAM byte address [7:0]
//               wdata      - RAM write word [127:0]
//               frame_done - one-cycle pulse after a word is committed
//               err        - sticky short-frame flag, cleared by reset
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader
    import ram_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [c_BYTE_W-1:0] in_data,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                rd_req,
    input  logic [c_ADDR_W-1:0] rd_addr,
    output logic                rd_gnt,
    output logic [1:0]          rw,
    output logic [c_ADDR_W-1:0] addr,
    output logic [c_WORD_W-1:0] wdata,
    output logic                frame_done,
    output logic                err
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    ldr_state_e          r_state_q,      w_state_d;
    logic [c_CNT_W-1:0]  r_cnt_q,        w_cnt_d;
    logic [c_WORD_W-1:0] r_buf_q,        w_buf_d;
    logic                r_err_q,        w_err_d;
    logic                r_in_ready_q,   w_in_ready_d;
    logic                r_frame_done_q, w_frame_done_d;

    logic                w_accept;
    logic                w_full;
    logic                w_commit;

    // in_ready is a registered decode of the state, so the handshake
    // only depends on flops.
    assign w_accept = in_valid & r_in_ready_q;
    assign w_full   = (r_cnt_q == c_CNT_W'(c_BYTES_PER_WORD - 1));
    assign w_commit = (r_state_q == ST_COMMIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_buf_d   = r_buf_q;
        w_err_d   = r_err_q;

        case (r_state_q)
            ST_FILL: begin
                if (w_accept) begin
                    w_buf_d = put_byte(r_buf_q, r_cnt_q, in_data);
                    w_cnt_d = r_cnt_q + 1'b1;
                    // A 16th byte always ends the frame normally, even
                    // when it also carries in_last.
                    if (w_full) begin
                        w_state_d = ST_COMMIT;
                    end else if (in_last) begin
`ifdef RAM_LOADER_PAD_EN
                        // Upper lanes are still zero: the buffer is cleared
                        // on every entry to FILL, so padding is implicit.
                        w_state_d = ST_COMMIT;
`else
                        // Short frame: drop it and flag the error.
                        w_buf_d   = '0;
                        w_cnt_d   = '0;
                        w_err_d   = 1'b1;
`endif
                    end
                end
            end
            ST_COMMIT: begin
                w_state_d = ST_DONE;
            end
            ST_DONE: begin
                w_state_d = ST_FILL;
                w_buf_d   = '0;
                w_cnt_d   = '0;
            end
            default: begin
                w_state_d = ST_FILL;
                w_buf_d   = '0;
                w_cnt_d   = '0;
            end
        endcase

        w_in_ready_d   = (w_state_d == ST_FILL);
        w_frame_done_d = (w_state_d == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q      <= ST_FILL;
            r_cnt_q        <= '0;
            r_buf_q        <= '0;
            r_err_q        <= 1'b0;
            r_in_ready_q   <= 1'b1;
            r_frame_done_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_buf_q        <= w_buf_d;
            r_err_q        <= w_err_d;
            r_in_ready_q   <= w_in_ready_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM command mux: the commit cycle owns the RAM; a read request
    // arriving then is refused and must be retried by the consumer.
    // ------------------------------------------------------------------
    always_comb begin
        rw     = RW_LOCK;
        addr   = '0;
        rd_gnt = 1'b0;
        if (w_commit) begin
            rw = RW_WRITE;
        end else if (rd_req) begin
            rw     = RW_READ;
            addr   = rd_addr;
            rd_gnt = 1'b1;
        end
    end

    assign in_ready   = r_in_ready_q;
    assign frame_done = r_frame_done_q;
    assign err        = r_err_q;
    assign wdata      = r_buf_q;

endmodule : ram_loader
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_loader
// Description : Self-checking bench for ram_loader. A frame-level model
//               (byte queue + countdown of the two post-frame cycles) predicts
//               every output each cycle; a small RAM image is filled from the
//               observed Write commands. Honors RAM_LOADER_PAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader;
    import ram_pkg::*;

`ifdef RAM_LOADER_PAD_EN
    localparam bit c_PAD = 1'b1;
`else
    localparam bit c_PAD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         rd_req;
    logic [7:0]   rd_addr;
    logic         rd_gnt;
    logic [1:0]   rw;
    logic [7:0]   addr;
    logic [127:0] wdata;
    logic         frame_done;
    logic         err;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rw         (rw),
        .addr       (addr),
        .wdata      (wdata),
        .frame_done (frame_done),
        .err        (err)
    );

    int           checks = 0;
    int           errors = 0;

    // Reference model state
    logic [7:0]   frame_q[$];
    int           hold = 0;       // 2 = commit cycle expected, 1 = done cycle
    logic         exp_err = 1'b0;
    logic [127:0] exp_word = '0;
    bit           rand_rd = 1'b0;

    // Observations
    int           writes = 0;
    logic [127:0] last_wdata = '0;
    logic [7:0]   ram_mem[16];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already set; sample at negedge, advance model.
    task automatic tick();
        logic acc;
        if (rand_rd) begin
            rd_req  = 1'($urandom);
            rd_addr = 8'($urandom);
        end
        @(negedge clk);
        chk("in_ready", in_ready, hold == 0);
        chk("frame_done", frame_done, hold == 1);
        chk("err", err, exp_err);
        if (hold == 2) begin
            chk("rw_commit", rw, RW_WRITE);
            chk("rd_gnt_commit", rd_gnt, 1'b0);
            chk("wdata_commit", wdata, exp_word);
        end else if (rd_req) begin
            chk("rw_read", rw, RW_READ);
            chk("addr_read", addr, rd_addr);
            chk("rd_gnt_read", rd_gnt, 1'b1);
        end else begin
            chk("rw_lock", rw, RW_LOCK);
            chk("addr_lock", addr, 8'h00);
            chk("rd_gnt_lock", rd_gnt, 1'b0);
        end
        if (rw === RW_WRITE) begin
            writes++;
            last_wdata = wdata;
            for (int k = 0; k < 16; k++) ram_mem[k] = wdata[8*k +: 8];
        end

        acc = rst_n && in_valid && (hold == 0);
        if (hold > 0) hold--;
        if (!rst_n) begin
            frame_q.delete();
            hold    = 0;
            exp_err = 1'b0;
        end else if (acc) begin
            frame_q.push_back(in_data);
            if (frame_q.size() == 16 || in_last) begin
                if (frame_q.size() == 16 || c_PAD) begin
                    exp_word = '0;
                    for (int k = 0; k < frame_q.size(); k++) exp_word[8*k +: 8] = frame_q[k];
                    hold = 2;
                end else begin
                    exp_err = 1'b1;
                end
                frame_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one byte after 'gap' idle cycles; hold it until accepted (bounded).
    task automatic send(input logic [7:0] b, input logic last, input int gap);
        bit was_ready;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        for (int i = 0; i < 8; i++) begin
            was_ready = (hold == 0);
            tick();
            if (was_ready) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int len;
        int wr_before;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        for (int k = 0; k < 16; k++) ram_mem[k] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rw", rw, RW_LOCK);
        chk("rst_addr", addr, 8'h00);
        chk("rst_wdata", wdata, 128'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_rd_gnt", rd_gnt, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // Continuous 0x00..0x0F, then read back address 5
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 0);
        idle(3);
        chk("f1_wdata", last_wdata, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("f1_writes", writes, 1);
        rd_req = 1'b1; rd_addr = 8'd5;
        tick();
        chk("ram_addr5", ram_mem[5], 8'h05);
        rd_req = 1'b0;

        // in_valid every other cycle
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1);
        idle(3);
        chk("f2_wdata", last_wdata, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("f2_writes", writes, 2);

        // Read request held across a commit
        rd_req = 1'b1; rd_addr = 8'd3;
        for (int i = 0; i < 16; i++) send(8'($urandom), i == 15, 0);
        idle(3);
        rd_req = 1'b0;
        chk("f3_writes", writes, 3);

        // Short frame 0xA1..0xA5
        for (int i = 0; i < 5; i++) send(8'hA1 + 8'(i), i == 4, 0);
        idle(3);
        if (c_PAD) begin
            chk("short_wdata", last_wdata, 128'hA5A4A3A2A1);
            chk("short_writes", writes, 4);
        end else begin
            chk("short_err", err, 1'b1);
            chk("short_writes", writes, 3);
        end

        // Reset after 10 bytes, then a clean frame
        wr_before = writes;
        for (int i = 0; i < 10; i++) send(8'h50 + 8'(i), 1'b0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_wdata", wdata, 128'h0);
        idle(3);
        chk("midrst_writes", writes, wr_before);
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 1'b0, 0);
        idle(3);
        chk("post_rst_wdata", last_wdata, 128'h3F3E3D3C3B3A39383736353433323130);

        // Two back-to-back frames (gap of in_ready checked every cycle)
        wr_before = writes;
        for (int i = 0; i < 32; i++) send(8'($urandom), 1'b0, 0);
        idle(3);
        chk("b2b_writes", writes, wr_before + 2);

        // Randomized frames with random read traffic
        rand_rd = 1'b1;
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                send(8'($urandom), i == len - 1, $urandom_range(0, 2));
        end
        idle(4);
        rand_rd = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_loader
`default_nettype wire
